ms_riscv32_mp_dmem_ctrl: RTL and testbench

MS_RISCV32_MP_DMEM_CTRL -- requirements
Module: ms_riscv32_mp_dmem_ctrl

---
 rtl/ms_riscv32_mp_pkg.sv | 28 ++
 rtl/ms_riscv32_mp_dmem_array.sv | 34 +++
 rtl/ms_riscv32_mp_dmem_ctrl.sv | 134 +++++++++++++
 tb/tb_ms_riscv32_mp_dmem_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ms_riscv32_mp_pkg.sv
// Shared definitions for the ms_riscv32_mp data-memory path.
// Contents:
//   htrans_e      - bus transfer type encodings (IDLE/BUSY/NONSEQ/SEQ)
//   dmem_state_e  - data-memory controller FSM states
//   htrans_active - true for transfer types that carry a real request
package ms_riscv32_mp_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } dmem_state_e;

  // NONSEQ and SEQ start a transfer; IDLE and BUSY never do.
  function automatic logic htrans_active(input logic [1:0] t);
    return (t == HTRANS_NONSEQ) || (t == HTRANS_SEQ);
  endfunction

endpackage

// File: rtl/ms_riscv32_mp_dmem_array.sv
// Word-organised backing store for the data-memory controller.
// One combinational read port, one synchronous byte-masked write port.
// Contents are never reset.
// Ports:
//   clk   - clock, write on rising edge
//   raddr - read word index;  rdata - read word (combinational)
//   we    - write enable;     waddr - write word index
//   wdata - write word;       wmask - byte-lane enables, bit i = byte i
module ms_riscv32_mp_dmem_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [3:0]    wmask
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wmask[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ms_riscv32_mp_dmem_ctrl.sv
// Data-memory slave for the ms_riscv32_mp core: pipelined address/data
// bus with programmable wait states and a two-cycle error response.
// Handshake: a request is taken in any cycle where hready is high and
// htrans is NONSEQ/SEQ; the address phase is that cycle, the data phase
// follows after WAIT_STATES low-hready cycles. hready high always means
// "the current data phase ends now and a new address may be taken".
// Ports:
//   ms_riscv32_mp_clk_in / rst_in     - clock, synchronous active-high reset
//   ms_riscv32_mp_dmaddr_in           - byte address
//   ms_riscv32_mp_dmdata_in           - write data (address-phase aligned)
//   ms_riscv32_mp_dmwr_req_in         - 1 = write, 0 = read
//   ms_riscv32_mp_dmwr_mask_in        - byte-lane write enables
//   ms_riscv32_mp_data_htrans_in      - transfer type
//   ms_riscv32_mp_data_out            - read data (zero outside read data phase)
//   ms_riscv32_mp_data_hready_out     - transfer done / ready
//   ms_riscv32_mp_hresp_out           - error response
module ms_riscv32_mp_dmem_ctrl
  import ms_riscv32_mp_pkg::*;
#(
  parameter int          MEM_DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
  parameter int          WAIT_STATES     = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] ms_riscv32_mp_dmaddr_in,
  input  logic [31:0] ms_riscv32_mp_dmdata_in,
  input  logic        ms_riscv32_mp_dmwr_req_in,
  input  logic [3:0]  ms_riscv32_mp_dmwr_mask_in,
  input  logic [1:0]  ms_riscv32_mp_data_htrans_in,
  output logic [31:0] ms_riscv32_mp_data_out,
  output logic        ms_riscv32_mp_data_hready_out,
  output logic        ms_riscv32_mp_hresp_out
);

  localparam int          AW   = (MEM_DEPTH_WORDS > 1) ? $clog2(MEM_DEPTH_WORDS) : 1;
  localparam logic [32:0] SPAN = 33'(MEM_DEPTH_WORDS) * 33'd4;

  dmem_state_e   state, state_nx;
  logic [3:0]    cnt, cnt_nx;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic [3:0]    mask_q;
  logic          wr_q;

  logic [31:0]   offset;
  logic          addr_err;
  logic          accept;
  logic          mem_we;
  logic [31:0]   rdata;

  // Offset is unsigned, so addresses below BASE_ADDR wrap high and fail
  // the span check together with those above the window.
  assign offset   = ms_riscv32_mp_dmaddr_in - BASE_ADDR;
  assign addr_err = ({1'b0, offset} >= SPAN) || (ms_riscv32_mp_dmaddr_in[1:0] != 2'b00);

  assign ms_riscv32_mp_data_hready_out = !((state == ST_WAIT) || (state == ST_ERR1));
  assign accept = ms_riscv32_mp_data_hready_out && htrans_active(ms_riscv32_mp_data_htrans_in);

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      wr_q    <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        idx_q   <= offset[AW+1:2];
        wdata_q <= ms_riscv32_mp_dmdata_in;
        mask_q  <= ms_riscv32_mp_dmwr_mask_in;
        wr_q    <= ms_riscv32_mp_dmwr_req_in;
      end
    end
  end

  always_comb begin
    state_nx                = state;
    cnt_nx                  = cnt;
    ms_riscv32_mp_hresp_out = 1'b0;
    case (state)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        ms_riscv32_mp_hresp_out = (state == ST_ERR2);
        state_nx = ST_IDLE;
        if (accept) begin
          if (addr_err) begin
            state_nx = ST_ERR1;
            cnt_nx   = '0;
          end else if (WAIT_STATES == 0) begin
            state_nx = ST_DATA;
            cnt_nx   = '0;
          end else begin
            state_nx = ST_WAIT;
            cnt_nx   = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) state_nx = ST_DATA;
      end
      ST_ERR1: begin
        ms_riscv32_mp_hresp_out = 1'b1;
        state_nx = ST_ERR2;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Commit happens on the edge that ends the write data phase; a reset on
  // that edge discards the pending write.
  assign mem_we = (state == ST_DATA) && wr_q && !ms_riscv32_mp_rst_in;

  // Because the write lands on the edge ending its data phase, a read data
  // phase in the next cycle already sees the new bytes without forwarding.
  assign ms_riscv32_mp_data_out = ((state == ST_DATA) && !wr_q) ? rdata : 32'h0;

  ms_riscv32_mp_dmem_array #(
    .DEPTH(MEM_DEPTH_WORDS),
    .AW   (AW)
  ) u_array (
    .clk  (ms_riscv32_mp_clk_in),
    .raddr(idx_q),
    .rdata(rdata),
    .we   (mem_we),
    .waddr(idx_q),
    .wdata(wdata_q),
    .wmask(mask_q)
  );

endmodule

// File: tb/tb_ms_riscv32_mp_dmem_ctrl.sv
// Bench for ms_riscv32_mp_dmem_ctrl: one instance with one wait state and
// one with none, sharing address/data inputs; htrans is routed to the
// selected instance only.
module tb_ms_riscv32_mp_dmem_ctrl;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [31:0] addr, wdata;
  logic        wr;
  logic [3:0]  mask;
  logic [1:0]  htrans;
  bit          sel;  // 0: no wait states, 1: one wait state

  logic [1:0]  htrans0, htrans1;
  assign htrans0 = sel ? 2'b00 : htrans;
  assign htrans1 = sel ? htrans : 2'b00;

  logic [31:0] data0, data1;
  logic        hready0, hready1, hresp0, hresp1;

  logic [31:0] cur_data;
  logic        cur_hready, cur_hresp;
  assign cur_data   = sel ? data1   : data0;
  assign cur_hready = sel ? hready1 : hready0;
  assign cur_hresp  = sel ? hresp1  : hresp0;

  ms_riscv32_mp_dmem_ctrl #(.WAIT_STATES(0)) u_dut_ws0 (
    .ms_riscv32_mp_clk_in         (clk),
    .ms_riscv32_mp_rst_in         (rst),
    .ms_riscv32_mp_dmaddr_in      (addr),
    .ms_riscv32_mp_dmdata_in      (wdata),
    .ms_riscv32_mp_dmwr_req_in    (wr),
    .ms_riscv32_mp_dmwr_mask_in   (mask),
    .ms_riscv32_mp_data_htrans_in (htrans0),
    .ms_riscv32_mp_data_out       (data0),
    .ms_riscv32_mp_data_hready_out(hready0),
    .ms_riscv32_mp_hresp_out      (hresp0)
  );

  ms_riscv32_mp_dmem_ctrl #(.WAIT_STATES(1)) u_dut_ws1 (
    .ms_riscv32_mp_clk_in         (clk),
    .ms_riscv32_mp_rst_in         (rst),
    .ms_riscv32_mp_dmaddr_in      (addr),
    .ms_riscv32_mp_dmdata_in      (wdata),
    .ms_riscv32_mp_dmwr_req_in    (wr),
    .ms_riscv32_mp_dmwr_mask_in   (mask),
    .ms_riscv32_mp_data_htrans_in (htrans1),
    .ms_riscv32_mp_data_out       (data1),
    .ms_riscv32_mp_data_hready_out(hready1),
    .ms_riscv32_mp_hresp_out      (hresp1)
  );

  // scoreboard
  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem_m [2][1024];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // drive one request at the next negedge and update the model
  task automatic drive_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] m, input bit err);
    addr = a; wdata = d; wr = w; mask = m; htrans = 2'b10;
    if (!w) exp_q.push_back(err ? 32'h0 : mem_m[sel][a[11:2]]);
    else if (!err) mem_m[sel][a[11:2]] = merge(mem_m[sel][a[11:2]], d, m);
  endtask

  // single non-pipelined transfer, checked through its whole lifetime
  task automatic xfer(input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] m, input bit err);
    int waits;
    int ws;
    ws = sel ? 1 : 0;
    @(negedge clk);
    check_eq("idle_hready", cur_hready, 1);
    check_eq("idle_hresp", cur_hresp, 0);
    drive_req(w, a, d, m, err);
    @(negedge clk);
    htrans = 2'b00;
    waits = 0;
    while (cur_hready == 1'b0 && waits < 40) begin
      check_eq(err ? "err1_hresp" : "wait_hresp", cur_hresp, err);
      check_eq("wait_data", cur_data, 0);
      waits++;
      @(negedge clk);
    end
    check_eq("wait_cycles", waits, err ? 1 : ws);
    check_eq("done_hresp", cur_hresp, err);
    if (!w) check_eq("rdata", cur_data, exp_q.pop_front());
    else    check_eq("wr_data_zero", cur_data, 0);
  endtask

  // back-to-back random stream on the zero-wait-state instance
  task automatic stream(input int n);
    bit          pend;
    bit          w;
    logic [31:0] a;
    logic [3:0]  m;
    pend = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("s_hready", cur_hready, 1);
      if (pend) check_eq("s_rdata", cur_data, exp_q.pop_front());
      else      check_eq("s_data_zero", cur_data, 0);
      if (i < 4) begin
        w = 1'b1; a = 32'h40 + 32'(4 * i); m = 4'hF;
      end else begin
        w = 1'($urandom_range(0, 1));
        a = 32'h40 + 32'(4 * $urandom_range(0, 3));
        m = 4'($urandom_range(0, 15));
      end
      drive_req(w, a, $urandom, m, 1'b0);
      pend = !w;
    end
    @(negedge clk);
    htrans = 2'b00;
    if (pend) check_eq("s_rdata_last", cur_data, exp_q.pop_front());
  endtask

  initial begin
    rst = 1'b1; htrans = 2'b00; addr = '0; wdata = '0; wr = 1'b0; mask = '0; sel = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("rst_hready0", hready0, 1);
    check_eq("rst_hresp0", hresp0, 0);
    check_eq("rst_data0", data0, 0);
    check_eq("rst_hready1", hready1, 1);
    check_eq("rst_hresp1", hresp1, 0);
    check_eq("rst_data1", data1, 0);
    rst = 1'b0;

    // one wait state: full write, masked write, empty-mask write
    sel = 1'b1;
    xfer(1, 32'h10, 32'hAABBCCDD, 4'hF, 0);
    xfer(0, 32'h10, 32'h0, 4'h0, 0);
    xfer(1, 32'h10, 32'h11223344, 4'b0010, 0);
    xfer(0, 32'h10, 32'h0, 4'h0, 0);
    check_eq("masked_word", mem_m[1][4], 32'hAABB33DD);
    xfer(1, 32'h10, 32'hFFFFFFFF, 4'h0, 0);
    xfer(0, 32'h10, 32'h0, 4'h0, 0);

    // error responses; aliased/misaligned writes must not touch memory
    xfer(0, 32'h0000_1000, 32'h0, 4'h0, 1);
    xfer(0, 32'h0000_0003, 32'h0, 4'h0, 1);
    xfer(1, 32'h0000_1010, 32'h0, 4'hF, 1);
    xfer(1, 32'h0000_0011, 32'h0, 4'hF, 1);
    xfer(0, 32'h10, 32'h0, 4'h0, 0);

    // IDLE and BUSY with write asserted are ignored
    for (int k = 0; k < 2; k++) begin
      addr = 32'h10; wdata = 32'h0; wr = 1'b1; mask = 4'hF;
      htrans = (k == 0) ? 2'b01 : 2'b00;
      repeat (5) begin
        @(negedge clk);
        check_eq("ign_hready", cur_hready, 1);
        check_eq("ign_hresp", cur_hresp, 0);
      end
    end
    htrans = 2'b00;
    xfer(0, 32'h10, 32'h0, 4'h0, 0);

    // reset during the wait state of a write
    xfer(1, 32'h30, 32'h12345678, 4'hF, 0);
    @(negedge clk);
    addr = 32'h30; wdata = 32'hDEADBEEF; wr = 1'b1; mask = 4'hF; htrans = 2'b10;
    @(negedge clk);
    check_eq("rstw_in_wait", cur_hready, 0);
    htrans = 2'b00; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstw_hready", cur_hready, 1);
    check_eq("rstw_hresp", cur_hresp, 0);
    check_eq("rstw_data", cur_data, 0);
    xfer(0, 32'h30, 32'h0, 4'h0, 0);

    // zero wait states
    sel = 1'b0;
    xfer(1, 32'h24, 32'hCAFE0001, 4'hF, 0);
    xfer(0, 32'h24, 32'h0, 4'h0, 0);
    @(negedge clk);
    drive_req(1, 32'h20, 32'h5, 4'hF, 0);
    @(negedge clk);
    check_eq("b2b_w_hready", cur_hready, 1);
    check_eq("b2b_w_data", cur_data, 0);
    drive_req(0, 32'h20, 32'h0, 4'h0, 0);
    @(negedge clk);
    htrans = 2'b00;
    check_eq("b2b_r_hready", cur_hready, 1);
    check_eq("b2b_r_data", cur_data, exp_q.pop_front());
    check_eq("b2b_r_five", mem_m[0][8], 32'h5);
    stream(60);

    // reset during the data phase of a write drops the commit
    xfer(1, 32'h50, 32'h0BADF00D, 4'hF, 0);
    @(negedge clk);
    addr = 32'h50; wdata = 32'h77777777; wr = 1'b1; mask = 4'hF; htrans = 2'b10;
    @(negedge clk);
    check_eq("rstd_in_data", cur_hready, 1);
    htrans = 2'b00; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("rstd_hready", cur_hready, 1);
    check_eq("rstd_data", cur_data, 0);
    xfer(0, 32'h50, 32'h0, 4'h0, 0);

    check_eq("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
